// File: rtl/cci_mpf_shim_vtp_miss_handler.sv
// VTP TLB miss handler: deduplicating miss queue feeding a single-outstanding
// page-table walker, turning walk responses into 4KB or 2MB TLB fills.
module cci_mpf_shim_vtp_miss_handler #(
   parameter int MISS_ENTRIES = 4,
   parameter int VA_IDX_BITS  = 36,
   parameter int PA_IDX_BITS  = 26
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   miss_en_0,
   input  logic [VA_IDX_BITS-1:0] miss_va_0,
   input  logic                   miss_en_1,
   input  logic [VA_IDX_BITS-1:0] miss_va_1,
   output logic                   miss_rdy,
   output logic                   walk_req_en,
   output logic [VA_IDX_BITS-1:0] walk_req_va,
   input  logic                   walk_req_rdy,
   input  logic                   walk_rsp_en,
   input  logic [PA_IDX_BITS-1:0] walk_rsp_pa,
   input  logic                   walk_rsp_big_page,
   input  logic                   walk_rsp_error,
   output logic                   fill_en,
   output logic [VA_IDX_BITS-1:0] fill_va,
   output logic [PA_IDX_BITS-1:0] fill_pa,
   output logic                   fill_big_page,
   input  logic                   fill_rdy,
   output logic                   err_valid,
   output logic [VA_IDX_BITS-1:0] err_va,
   output logic                   busy
);

   localparam int PW = $clog2(MISS_ENTRIES);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, FILL} state_t;

   state_t                  state_q, state_d;
   logic [VA_IDX_BITS-1:0]  slot_va_q [MISS_ENTRIES];
   logic [VA_IDX_BITS-1:0]  slot_va_d [MISS_ENTRIES];
   logic [MISS_ENTRIES-1:0] slot_valid_q, slot_valid_d;
   logic [MISS_ENTRIES-1:0] slot_cov_q, slot_cov_d;
   logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    miss_rdy_q, miss_rdy_d;
   logic [VA_IDX_BITS-1:0]  req_va_q, req_va_d;
   logic [VA_IDX_BITS-1:0]  fill_va_q, fill_va_d;
   logic [PA_IDX_BITS-1:0]  fill_pa_q, fill_pa_d;
   logic                    fill_big_q, fill_big_d;
   logic                    err_valid_q, err_valid_d;
   logic [VA_IDX_BITS-1:0]  err_va_q, err_va_d;

   logic                    pop, big_fill_hs;
   logic                    hit0, hit1, enq0, enq1;
   logic [PW-1:0]           idx1;

   always_comb begin
      state_d      = state_q;
      slot_va_d    = slot_va_q;
      slot_valid_d = slot_valid_q;
      slot_cov_d   = slot_cov_q;
      head_d       = head_q;
      tail_d       = tail_q;
      req_va_d     = req_va_q;
      fill_va_d    = fill_va_q;
      fill_pa_d    = fill_pa_q;
      fill_big_d   = fill_big_q;
      err_valid_d  = err_valid_q;
      err_va_d     = err_va_q;
      pop          = 1'b0;
      big_fill_hs  = (state_q == FILL) && fill_rdy && fill_big_q;
      hit0         = 1'b0;
      hit1         = 1'b0;
      enq0         = 1'b0;
      enq1         = 1'b0;
      idx1         = tail_q;

      case (state_q)
         IDLE: begin
            if (slot_valid_q[head_q]) begin
               if (slot_cov_q[head_q]) begin
                  pop = 1'b1;
               end else begin
                  req_va_d = slot_va_q[head_q];
                  state_d  = REQ;
               end
            end
         end
         REQ: begin
            if (walk_req_rdy) state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (walk_rsp_en) begin
               if (walk_rsp_error) begin
                  pop     = 1'b1;
                  state_d = IDLE;
                  if (!err_valid_q) begin
                     err_valid_d = 1'b1;
                     err_va_d    = req_va_q;
                  end
               end else begin
                  fill_big_d = walk_rsp_big_page;
                  fill_va_d  = walk_rsp_big_page ? {req_va_q[VA_IDX_BITS-1:9], 9'b0} : req_va_q;
                  fill_pa_d  = walk_rsp_big_page ? {walk_rsp_pa[PA_IDX_BITS-1:9], 9'b0} : walk_rsp_pa;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            if (fill_rdy) begin
               pop     = 1'b1;
               state_d = IDLE;
               // A 2MB fill makes later queued misses in the same large page redundant
               if (fill_big_q) begin
                  for (int i = 0; i < MISS_ENTRIES; i++) begin
                     if (slot_valid_q[i] && (PW'(i) != head_q) &&
                         (slot_va_q[i][VA_IDX_BITS-1:9] == fill_va_q[VA_IDX_BITS-1:9]))
                        slot_cov_d[i] = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         slot_valid_d[head_q] = 1'b0;
         slot_cov_d[head_q]   = 1'b0;
         head_d               = head_q + PW'(1);
      end

      for (int i = 0; i < MISS_ENTRIES; i++) begin
         if (slot_valid_q[i] && (slot_va_q[i] == miss_va_0)) hit0 = 1'b1;
         if (slot_valid_q[i] && (slot_va_q[i] == miss_va_1)) hit1 = 1'b1;
      end

      enq0 = miss_en_0 && !hit0 &&
             !(big_fill_hs && (miss_va_0[VA_IDX_BITS-1:9] == fill_va_q[VA_IDX_BITS-1:9]));
      enq1 = miss_en_1 && !hit1 && !(miss_en_0 && (miss_va_1 == miss_va_0)) &&
             !(big_fill_hs && (miss_va_1[VA_IDX_BITS-1:9] == fill_va_q[VA_IDX_BITS-1:9]));

      if (enq0) begin
         slot_va_d[tail_q]    = miss_va_0;
         slot_valid_d[tail_q] = 1'b1;
         slot_cov_d[tail_q]   = 1'b0;
      end
      idx1 = tail_q + PW'(enq0);
      if (enq1) begin
         slot_va_d[idx1]    = miss_va_1;
         slot_valid_d[idx1] = 1'b1;
         slot_cov_d[idx1]   = 1'b0;
      end
      tail_d = tail_q + PW'(enq0) + PW'(enq1);

      count_d    = count_q + CW'(enq0) + CW'(enq1) - CW'(pop);
      miss_rdy_d = (count_d <= CW'(MISS_ENTRIES - 2));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         slot_va_q    <= '{default: '0};
         slot_valid_q <= '0;
         slot_cov_q   <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         miss_rdy_q   <= 1'b1;
         req_va_q     <= '0;
         fill_va_q    <= '0;
         fill_pa_q    <= '0;
         fill_big_q   <= 1'b0;
         err_valid_q  <= 1'b0;
         err_va_q     <= '0;
      end else begin
         state_q      <= state_d;
         slot_va_q    <= slot_va_d;
         slot_valid_q <= slot_valid_d;
         slot_cov_q   <= slot_cov_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         miss_rdy_q   <= miss_rdy_d;
         req_va_q     <= req_va_d;
         fill_va_q    <= fill_va_d;
         fill_pa_q    <= fill_pa_d;
         fill_big_q   <= fill_big_d;
         err_valid_q  <= err_valid_d;
         err_va_q     <= err_va_d;
      end
   end

   assign miss_rdy      = miss_rdy_q;
   assign walk_req_en   = (state_q == REQ);
   assign walk_req_va   = req_va_q;
   assign fill_en       = (state_q == FILL);
   assign fill_va       = fill_va_q;
   assign fill_pa       = fill_pa_q;
   assign fill_big_page = fill_big_q;
   assign err_valid     = err_valid_q;
   assign err_va        = err_va_q;
   assign busy          = (count_q != '0) || (state_q != IDLE);

   miss_proto_a: assert property (@(posedge clk) disable iff (!reset_n)
      !((miss_en_0 || miss_en_1) && !miss_rdy_q));

endmodule

// File: tb/tb_cci_mpf_shim_vtp_miss_handler.sv
// Self-checking bench for the VTP miss handler: table-driven single walks plus
// hand-written dedup, 2MB coverage, backpressure, error and reset sequences.
module tb_cci_mpf_shim_vtp_miss_handler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        miss_en_0, miss_en_1;
   logic [35:0] miss_va_0, miss_va_1;
   logic        miss_rdy;
   logic        walk_req_en;
   logic [35:0] walk_req_va;
   logic        walk_req_rdy;
   logic        walk_rsp_en;
   logic [25:0] walk_rsp_pa;
   logic        walk_rsp_big_page, walk_rsp_error;
   logic        fill_en;
   logic [35:0] fill_va;
   logic [25:0] fill_pa;
   logic        fill_big_page, fill_rdy;
   logic        err_valid;
   logic [35:0] err_va;
   logic        busy;

   cci_mpf_shim_vtp_miss_handler #(.MISS_ENTRIES(4), .VA_IDX_BITS(36), .PA_IDX_BITS(26)) dut (
      .clk(clk), .reset_n(reset_n),
      .miss_en_0(miss_en_0), .miss_va_0(miss_va_0),
      .miss_en_1(miss_en_1), .miss_va_1(miss_va_1),
      .miss_rdy(miss_rdy),
      .walk_req_en(walk_req_en), .walk_req_va(walk_req_va), .walk_req_rdy(walk_req_rdy),
      .walk_rsp_en(walk_rsp_en), .walk_rsp_pa(walk_rsp_pa),
      .walk_rsp_big_page(walk_rsp_big_page), .walk_rsp_error(walk_rsp_error),
      .fill_en(fill_en), .fill_va(fill_va), .fill_pa(fill_pa),
      .fill_big_page(fill_big_page), .fill_rdy(fill_rdy),
      .err_valid(err_valid), .err_va(err_va), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [35:0] va;
      logic [25:0] pa;
      logic        big;
   } fill_t;

   typedef struct {
      logic [35:0] va;
      logic [25:0] pa;
      logic        big;
      logic [35:0] exp_fva;
      logic [25:0] exp_fpa;
   } vec_t;

   logic [35:0] exp_walk_q [$];
   fill_t       exp_fill_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every walk request and fill handshake must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n) begin
         if (walk_req_en && walk_req_rdy) begin
            if (exp_walk_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("[TB] FAIL unexpected_walk: got va 0x%0h expected none", walk_req_va);
            end else begin
               check("walk_req_va", walk_req_va, exp_walk_q.pop_front());
            end
         end
         if (fill_en && fill_rdy) begin
            if (exp_fill_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("[TB] FAIL unexpected_fill: got va 0x%0h expected none", fill_va);
            end else begin
               fill_t f;
               f = exp_fill_q.pop_front();
               check("fill_va", fill_va, f.va);
               check("fill_pa", fill_pa, f.pa);
               check("fill_big_page", fill_big_page, f.big);
            end
         end
      end
   end

   function automatic fill_t model_fill(input logic [35:0] va, input logic [25:0] pa, input logic big);
      fill_t f;
      f.va  = big ? {va[35:9], 9'h000} : va;
      f.pa  = big ? {pa[25:9], 9'h000} : pa;
      f.big = big;
      return f;
   endfunction

   task automatic wait_walk_req();
      int n = 0;
      while (!walk_req_en && n < 50) begin tick(); n++; end
      check("walk_req_wait", walk_req_en, 1);
   endtask

   task automatic wait_fill();
      int n = 0;
      while (!fill_en && n < 50) begin tick(); n++; end
      check("fill_wait", fill_en, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin tick(); n++; end
      check("busy_drain", busy, 0);
   endtask

   task automatic accept_walk();
      wait_walk_req();
      walk_req_rdy = 1'b1;
      tick();
      walk_req_rdy = 1'b0;
   endtask

   task automatic respond(input logic [25:0] pa, input logic big, input logic err);
      walk_rsp_pa       = pa;
      walk_rsp_big_page = big;
      walk_rsp_error    = err;
      walk_rsp_en       = 1'b1;
      tick();
      walk_rsp_en       = 1'b0;
      walk_rsp_error    = 1'b0;
   endtask

   task automatic accept_fill(input int stall);
      wait_fill();
      for (int i = 0; i < stall; i++) begin
         check("fill_en_hold", fill_en, 1);
         if (exp_fill_q.size() != 0) begin
            check("fill_va_hold", fill_va, exp_fill_q[0].va);
            check("fill_pa_hold", fill_pa, exp_fill_q[0].pa);
         end
         tick();
      end
      fill_rdy = 1'b1;
      tick();
      fill_rdy = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      fill_t f;
      check("vec_miss_rdy", miss_rdy, 1);
      miss_en_0 = 1'b1;
      miss_va_0 = v.va;
      exp_walk_q.push_back(v.va);
      f.va = v.exp_fva; f.pa = v.exp_fpa; f.big = v.big;
      exp_fill_q.push_back(f);
      tick();
      miss_en_0 = 1'b0;
      check("lat_t1_req", walk_req_en, 0);
      check("lat_t1_busy", busy, 1);
      tick();
      check("lat_t2_req", walk_req_en, 1);
      accept_walk();
      respond(v.pa, v.big, 1'b0);
      accept_fill(0);
   endtask

   task automatic checkOutput();
      wait_idle();
      check("vec_err_valid", err_valid, 0);
      check("vec_miss_rdy_after", miss_rdy, 1);
      check("vec_walk_q_empty", exp_walk_q.size(), 0);
      check("vec_fill_q_empty", exp_fill_q.size(), 0);
   endtask

   vec_t vecs [3];

   initial begin
      vecs[0] = '{va: 36'h123456789, pa: 26'h0ABCDEF, big: 1'b0, exp_fva: 36'h123456789, exp_fpa: 26'h0ABCDEF};
      vecs[1] = '{va: 36'h987654321, pa: 26'h2345678, big: 1'b1, exp_fva: 36'h987654200, exp_fpa: 26'h2345600};
      vecs[2] = '{va: 36'hFFFFFFFFF, pa: 26'h3FFFFFF, big: 1'b0, exp_fva: 36'hFFFFFFFFF, exp_fpa: 26'h3FFFFFF};

      reset_n = 1'b0;
      miss_en_0 = 1'b0; miss_en_1 = 1'b0; miss_va_0 = '0; miss_va_1 = '0;
      walk_req_rdy = 1'b0; walk_rsp_en = 1'b0; walk_rsp_pa = '0;
      walk_rsp_big_page = 1'b0; walk_rsp_error = 1'b0; fill_rdy = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();

      check("rst_miss_rdy", miss_rdy, 1);
      check("rst_walk_req_en", walk_req_en, 0);
      check("rst_fill_en", fill_en, 0);
      check("rst_err_valid", err_valid, 0);
      check("rst_busy", busy, 0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // Dedup: both ports same VA, then a repeat while the walk is outstanding
      $display("[TB] dedup");
      miss_en_0 = 1'b1; miss_va_0 = 36'h40;
      miss_en_1 = 1'b1; miss_va_1 = 36'h40;
      exp_walk_q.push_back(36'h40);
      exp_fill_q.push_back(model_fill(36'h40, 26'h55, 1'b0));
      tick();
      miss_en_0 = 1'b0; miss_en_1 = 1'b0;
      accept_walk();
      check("dedup_miss_rdy", miss_rdy, 1);
      miss_en_1 = 1'b1; miss_va_1 = 36'h40;
      tick();
      miss_en_1 = 1'b0;
      respond(26'h55, 1'b0, 1'b0);
      accept_fill(0);
      wait_idle();
      check("dedup_no_walk", walk_req_en, 0);

      // 2MB coverage: 0x201 and 0x3FF ride on the 0x200 large-page fill
      $display("[TB] 2MB coverage");
      miss_en_0 = 1'b1; miss_va_0 = 36'h200;
      miss_en_1 = 1'b1; miss_va_1 = 36'h201;
      exp_walk_q.push_back(36'h200);
      tick();
      check("cov_miss_rdy_2", miss_rdy, 1);
      miss_va_0 = 36'h3FF; miss_va_1 = 36'h400;
      exp_walk_q.push_back(36'h400);
      tick();
      miss_en_0 = 1'b0; miss_en_1 = 1'b0;
      check("cov_miss_rdy_full", miss_rdy, 0);
      exp_fill_q.push_back(model_fill(36'h200, 26'h1000, 1'b1));
      accept_walk();
      respond(26'h1000, 1'b1, 1'b0);
      accept_fill(0);
      exp_fill_q.push_back(model_fill(36'h400, 26'h2222, 1'b0));
      accept_walk();
      respond(26'h2222, 1'b0, 1'b0);
      accept_fill(0);
      wait_idle();

      // Miss in same 2MB page arriving on the big fill handshake is dropped
      $display("[TB] drop on big fill");
      miss_en_0 = 1'b1; miss_va_0 = 36'h600;
      exp_walk_q.push_back(36'h600);
      exp_fill_q.push_back(model_fill(36'h600, 26'h4321, 1'b1));
      tick();
      miss_en_0 = 1'b0;
      accept_walk();
      respond(26'h4321, 1'b1, 1'b0);
      wait_fill();
      fill_rdy = 1'b1;
      miss_en_0 = 1'b1; miss_va_0 = 36'h655;
      tick();
      fill_rdy = 1'b0; miss_en_0 = 1'b0;
      wait_idle();
      check("drop_no_walk", walk_req_en, 0);

      // Backpressure on the miss queue, walk request and fill
      $display("[TB] backpressure");
      for (int i = 0; i < 3; i++) begin
         miss_en_0 = 1'b1; miss_va_0 = 36'h11 + 36'(i);
         exp_walk_q.push_back(36'h11 + 36'(i));
         tick();
         miss_en_0 = 1'b0;
         check("bp_miss_rdy", miss_rdy, (i < 2) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) begin
         check("bp_req_hold_en", walk_req_en, 1);
         check("bp_req_hold_va", walk_req_va, 36'h11);
         tick();
      end
      exp_fill_q.push_back(model_fill(36'h11, 26'h100, 1'b0));
      accept_walk();
      respond(26'h100, 1'b0, 1'b0);
      accept_fill(5);
      check("bp_miss_rdy_after_pop", miss_rdy, 1);
      for (int i = 1; i < 3; i++) begin
         exp_fill_q.push_back(model_fill(36'h11 + 36'(i), 26'h100 + 26'(i), 1'b0));
         accept_walk();
         respond(26'h100 + 26'(i), 1'b0, 1'b0);
         accept_fill(0);
      end
      wait_idle();

      // Errors: only the first erroring VA is latched, no fills
      $display("[TB] error");
      miss_en_0 = 1'b1; miss_va_0 = 36'h77;
      miss_en_1 = 1'b1; miss_va_1 = 36'h88;
      exp_walk_q.push_back(36'h77);
      exp_walk_q.push_back(36'h88);
      tick();
      miss_en_0 = 1'b0; miss_en_1 = 1'b0;
      accept_walk();
      respond(26'h0, 1'b0, 1'b1);
      check("err1_fill_en", fill_en, 0);
      check("err1_valid", err_valid, 1);
      check("err1_va", err_va, 36'h77);
      accept_walk();
      respond(26'h0, 1'b0, 1'b1);
      check("err2_fill_en", fill_en, 0);
      wait_idle();
      check("err2_va", err_va, 36'h77);

      // Reset while waiting for a walk response
      $display("[TB] reset mid-walk");
      miss_en_0 = 1'b1; miss_va_0 = 36'h99;
      exp_walk_q.push_back(36'h99);
      tick();
      miss_en_0 = 1'b0;
      accept_walk();
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_walk_req_en", walk_req_en, 0);
      check("mid_rst_fill_en", fill_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_miss_rdy", miss_rdy, 1);
      check("mid_rst_err_valid", err_valid, 0);
      check("mid_rst_err_va", err_va, 0);
      tick();
      reset_n = 1'b1;
      tick();
      respond(26'h3333, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("post_rst_fill_en", fill_en, 0);
         check("post_rst_busy", busy, 0);
         tick();
      end

      check("end_walk_q_empty", exp_walk_q.size(), 0);
      check("end_fill_q_empty", exp_fill_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cci_mpf_shim_vtp_miss_handler.md
Name: cci_mpf_shim_vtp_miss_handler

Overview:
- Sits directly downstream of the VTP TLB server's miss outputs and upstream of its fill port.
- Collects TLB misses from both lookup channels into a small deduplicating queue.
- Serialises page-table-walk requests, one walk in flight at a time.
- Converts each walk response into a TLB fill: VA/PA page indices at 4KB granularity, plus a 2MB flag.

Parameters:
MISS_ENTRIES, 4, miss queue depth; power of 2, >=2
VA_IDX_BITS, 36, 4KB virtual page index width (42-6)
PA_IDX_BITS, 26, 4KB physical page index width (32-6)

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
miss_en_0  in  1  channel 0 miss strobe
miss_va_0  in  VA_IDX_BITS  channel 0 missing 4KB VA page index
miss_en_1  in  1  channel 1 miss strobe
miss_va_1  in  VA_IDX_BITS  channel 1 missing 4KB VA page index
miss_rdy  out  1  at least 2 free queue slots
walk_req_en  out  1  walk request valid
walk_req_va  out  VA_IDX_BITS  VA page to walk
walk_req_rdy  in  1  walker accepts request
walk_rsp_en  in  1  walk response strobe
walk_rsp_pa  in  PA_IDX_BITS  translated 4KB PA page index
walk_rsp_big_page  in  1  translation is a 2MB page
walk_rsp_error  in  1  no translation exists
fill_en  out  1  TLB fill valid
fill_va  out  VA_IDX_BITS  fill VA (2MB-aligned, low 9 bits zero, when fill_big_page)
fill_pa  out  PA_IDX_BITS  fill PA (2MB-aligned likewise)
fill_big_page  out  1  2MB fill
fill_rdy  in  1  TLB accepts fill
err_valid  out  1  sticky: a walk returned an error
err_va  out  VA_IDX_BITS  VA of first erroring walk
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset values (async assert on reset_n=0): all outputs 0 except miss_rdy=1. Queue empty, FSM IDLE. Reset mid-walk abandons the walk. Any walk_rsp_en arriving after reset while not in WAIT_RSP is ignored.
- Queue: circular FIFO, per-slot valid + covered bits.
  - miss_en_x asserted while miss_rdy=0 is a protocol violation; the simulation assertion fires.
- Enqueue (per edge):
  - Port 0 is processed before port 1.
  - An incoming VA is dropped if it equals any valid slot's VA, including the in-flight head.
  - If both ports carry the same VA in the same cycle, it is enqueued once.
  - An arrival in the same cycle as a 2MB fill handshake whose VA[VA_IDX_BITS-1:9] matches the fill is dropped.
- FSM states: IDLE, REQ, WAIT_RSP, FILL.
  - IDLE, head valid and covered: pop the head in 1 cycle, stay IDLE.
  - IDLE, head valid and not covered: go to REQ. walk_req_va comes from a register loaded from the head VA.
  - REQ: walk_req_en=1, held stable until walk_req_rdy; then go to WAIT_RSP.
  - WAIT_RSP, walk_rsp_en with error=0: capture pa and big_page, go to FILL.
  - WAIT_RSP, walk_rsp_en with error=1: pop the head, no fill. If err_valid=0, set err_valid and latch err_va. Go to IDLE.
  - FILL: fill_en=1, held stable until fill_rdy. On handshake, pop the head and go to IDLE.
    - If big page: fill_va = {va[35:9],9'b0} and fill_pa = {pa[25:9],9'b0}.
    - If big page: set covered on every other valid slot with the same VA[35:9].
- Latency: a miss sampled at edge t gives walk_req_en=1 in cycle t+2 (IDLE at t+1). Minimum round trip per walk is 4 cycles plus walker latency.
- miss_rdy = (occupancy <= MISS_ENTRIES-2), registered. Occupancy counter width is log2(MISS_ENTRIES)+1; it never wraps.
- Simultaneous enqueue and pop in the same cycle: occupancy changes by the net amount.
- err_valid is cleared only by reset.

Test Plan:
- Single miss: miss_en_0=1, va=0x123456789; walker rdy immediately, rsp pa=0x0ABCDEF, big=0 -> walk_req_en at t+2 with va=0x123456789; fill_en with fill_va=0x123456789, fill_pa=0x0ABCDEF, fill_big_page=0; busy returns to 0.
- Dedup: both ports va=0x40 in the same cycle, then port 1 va=0x40 again while the walk is in flight -> exactly one walk_req_en.
- 2MB coverage: misses 0x200, 0x201, 0x3FF, 0x400; the first walk returns big=1, pa=0x1000 -> fill_va=0x200, fill_pa=0x1000, fill_big_page=1; 0x201 and 0x3FF pop without walks; next walk_req_va=0x400.
- Backpressure: MISS_ENTRIES=4, walker rdy=0, enqueue 3 distinct VAs -> miss_rdy=0 after occupancy 3; fill_rdy=0 for 5 cycles holds fill_en and fill_va/fill_pa stable.
- Error: walk for 0x77 returns error=1, then walk for 0x88 returns error=1 -> no fill_en; err_valid=1, err_va=0x77; the queue drains.
- Reset mid-walk: assert reset_n=0 while in WAIT_RSP -> all outputs drop immediately and miss_rdy=1; a walk_rsp_en after release is ignored and produces no fill.
